serial_adder8_fa1bit: RTL and testbench

Bit-serial WIDTH-bit adder built around a single 1-bit full-adder cell. It is the addition counterpart of the parallel 8-bit subtractor in the arithmetic library. Operands are latched on a start handshake and processed LSB-first, one bit per clock. It produces S/Cout with a one-cycle done pulse, and suits area-constrained datapaths that can tolerate WIDTH-cycle latency.

---
 rtl/serial_adder8_fa1bit.sv | 112 +++++++++++
 tb/tb_serial_adder8_fa1bit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder8_fa1bit.sv
// Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell, LSB first.
// Define SUB_MODE_EN to add the `sub` input, which turns the operation into A-B with a borrow out.
module serial_adder8_fa1bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_sub;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sub_req;
  logic             w_s;
  logic             w_cn;
  logic             w_last;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

`ifdef SUB_MODE_EN
  assign w_sub_req = sub;
`else
  assign w_sub_req = 1'b0;
`endif

  // The single full-adder cell, fed by the operand LSBs and the running carry.
  assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cn       = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_res_next = (r_res >> 1) | {w_s, {(WIDTH-1){1'b0}}};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // In subtract mode the final carry is inverted so Cout reads as a borrow.
  assign w_cout     = r_sub ? ~w_cn : w_cn;

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= w_sub_req ? ~B : B;
            r_carry <= w_sub_req ? 1'b1 : Cin;
            r_sub   <= w_sub_req;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_res   <= w_res_next;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cn;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            S       <= w_res_next;
            Cout    <= w_cout;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder8_fa1bit.sv
// Self-checking bench for serial_adder8_fa1bit: directed cases plus random operands
// checked against an arithmetic reference model. Honours SUB_MODE_EN when defined.
module tb_serial_adder8_fa1bit;

  localparam int WIDTH = 8;
  localparam int TMO   = WIDTH + 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             sub_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder8_fa1bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Cin   (cin_in),
`ifdef SUB_MODE_EN
    .sub   (sub_in),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {Cout,S} = A+B+Cin; subtract gives A-B mod 2^WIDTH with borrow = (A<B).
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, b,
                                           input logic cin, sub);
    logic [WIDTH:0] r;
    if (sub) begin
      r[WIDTH-1:0] = a - b;
      r[WIDTH]     = (a < b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, SHIFT with outputs held, done pulse, return to idle.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic cin, sub, input string tag);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] s_hold;
    logic             c_hold;
    int               n;
    exp    = model(a, b, cin, sub);
    s_hold = S;
    c_hold = Cout;
    a_in   = a;
    b_in   = b;
    cin_in = cin;
    sub_in = sub;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check({tag, ".busy_accept"}, busy, 1);
    n = 0;
    while (done !== 1'b1 && n < TMO) begin
      check({tag, ".s_hold"}, S, s_hold);
      check({tag, ".c_hold"}, Cout, c_hold);
      check({tag, ".busy_shift"}, busy, 1);
      tick();
      n++;
    end
    check({tag, ".latency"}, n, WIDTH);
    check({tag, ".S"}, S, exp[WIDTH-1:0]);
    check({tag, ".Cout"}, Cout, exp[WIDTH]);
    check({tag, ".busy_done"}, busy, 1);
    tick();
    check({tag, ".done_fall"}, done, 0);
    check({tag, ".busy_fall"}, busy, 0);
  endtask

  initial begin
    logic [WIDTH:0] exp;
    int             last;
    int             nd;

    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    sub_in = 1'b0;
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.S", S, 0);
    check("rst.Cout", Cout, 0);
    rst_n = 1'b1;
    tick();

    // Directed add cases, including a carry out of the MSB and Cin=1.
    run_op(8'd255, 8'd15, 1'b0, 1'b0, "add255_15");
    run_op(8'd10, 8'd50, 1'b0, 1'b0, "add10_50");
    run_op(8'd15, 8'd15, 1'b1, 1'b0, "add15_15c");

    // start pulses during SHIFT (cycle 3) and on the completion edge (cycle WIDTH) are ignored.
    exp    = model(8'd55, 8'd39, 1'b0, 1'b0);
    a_in   = 8'd55;
    b_in   = 8'd39;
    cin_in = 1'b0;
    start  = 1'b1;
    tick();
    for (int i = 1; i <= WIDTH; i++) begin
      start = (i == 3 || i == WIDTH);
      a_in  = 8'd1;
      b_in  = 8'd1;
      tick();
      check($sformatf("ign.done_c%0d", i), done, (i == WIDTH) ? 1 : 0);
    end
    start = 1'b0;
    check("ign.S", S, exp[WIDTH-1:0]);
    check("ign.Cout", Cout, exp[WIDTH]);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      check("ign.no_requeue_busy", busy, 0);
      check("ign.no_requeue_done", done, 0);
    end
    check("ign.S_hold", S, exp[WIDTH-1:0]);

    // Reset asserted mid-operation clears everything and no done follows.
    a_in  = 8'd200;
    b_in  = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.S", S, 0);
    check("midrst.Cout", Cout, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      check("midrst.no_done", done, 0);
      check("midrst.idle", busy, 0);
    end
    run_op(8'd20, 8'd14, 1'b0, 1'b0, "after_rst");

    // start held high: one accept every WIDTH+2 cycles.
    exp    = model(8'd21, 8'd15, 1'b0, 1'b0);
    a_in   = 8'd21;
    b_in   = 8'd15;
    cin_in = 1'b0;
    start  = 1'b1;
    last   = -1;
    nd     = 0;
    for (int t = 1; t <= 3 * (WIDTH + 2); t++) begin
      tick();
      if (done === 1'b1) begin
        nd++;
        check("b2b.S", S, exp[WIDTH-1:0]);
        check("b2b.Cout", Cout, exp[WIDTH]);
        if (last >= 0) check("b2b.spacing", t - last, WIDTH + 2);
        else check("b2b.first", t, WIDTH + 1);
        last = t;
      end
    end
    start = 1'b0;
    check("b2b.count", nd, 3);
    tick();
    tick();
    check("b2b.idle", busy, 0);

`ifdef SUB_MODE_EN
    run_op(8'd10, 8'd50, 1'b0, 1'b1, "sub10_50");
    run_op(8'd15, 8'd15, 1'b1, 1'b1, "sub15_15");
    run_op(8'd255, 8'd14, 1'b0, 1'b1, "sub255_14");
`endif

    // Random operands against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      logic             rs;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SUB_MODE_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
